// File: rtl/gf2k_exp_ctrl_if.sv
// Handshake and multiplier-IP bundle for the GF(2^k) exponentiation sequencer.
//   in_valid/in_poly/in_base/in_exp : job request from the upstream block
//   busy/out_valid/out_result       : status and result toward the upstream block
//   ip_poly/ip_in1/ip_in2           : operands driven into the shared GF multiplier IP
//   ip_result                       : combinational product returned by the IP
// The slave modport is the sequencer's view of the bundle.
// The master modport is the view of the environment: the job source and the IP.
interface gf2k_exp_ctrl_if #(
   parameter int DEG   = 4,
   parameter int EXP_W = 4
);
   logic             in_valid;
   logic [DEG:0]     in_poly;
   logic [DEG-1:0]   in_base;
   logic [EXP_W-1:0] in_exp;
   logic             busy;
   logic             out_valid;
   logic [DEG-1:0]   out_result;
   logic [DEG:0]     ip_poly;
   logic [DEG-1:0]   ip_in1;
   logic [DEG-1:0]   ip_in2;
   logic [DEG-1:0]   ip_result;

   modport slave (
      input  in_valid, in_poly, in_base, in_exp, ip_result,
      output busy, out_valid, out_result, ip_poly, ip_in1, ip_in2
   );

   modport master (
      output in_valid, in_poly, in_base, in_exp, ip_result,
      input  busy, out_valid, out_result, ip_poly, ip_in1, ip_in2
   );
endinterface

// File: rtl/gf2k_exp_ctrl.sv
// Sequencer computing base^exp in GF(2^DEG) by left-to-right square-and-multiply.
// All field arithmetic is done by one external, purely combinational GF multiplier.
// This block only steers operands into that multiplier and captures its product,
// one product per clock.
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active-high; aborts any job in flight
//   bus.slave  : request/result handshake plus the multiplier operand/result lines
//                (see gf2k_exp_ctrl_if)
// Timing: a job accepted in cycle T delivers out_valid in cycle T+1+EXP_W+popcount(exp).
module gf2k_exp_ctrl #(
   parameter int DEG   = 4,
   parameter int EXP_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   gf2k_exp_ctrl_if.slave  bus
);

   // Bit index into the exponent; kept at least one bit wide for EXP_W == 1.
   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SQ   = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [DEG-1:0]   ONE      = {{(DEG-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_W - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [1:0]       state_reg, state_next;
   logic [DEG:0]     poly_reg,  poly_next;
   logic [DEG-1:0]   base_reg,  base_next;
   logic [EXP_W-1:0] exp_reg,   exp_next;
   logic [DEG-1:0]   acc_reg,   acc_next;
   logic [IDX_W-1:0] idx_reg,   idx_next;

   logic [DEG-1:0]   in1_next;
   logic [DEG-1:0]   in2_next;
   logic             is_done;
   logic             exp_bit;
   logic             idx_last;

   // Exponent bit currently being scanned, MSB first.
   assign exp_bit  = exp_reg[idx_reg];
   assign idx_last = (idx_reg == IDX_ZERO);

   always_comb begin
      state_next = state_reg;
      poly_next  = poly_reg;
      base_next  = base_reg;
      exp_next   = exp_reg;
      acc_next   = acc_reg;
      idx_next   = idx_reg;
      in1_next   = '0;
      in2_next   = '0;

      case (state_reg)
         S_IDLE: begin
            if (bus.in_valid) begin
               poly_next  = bus.in_poly;
               base_next  = bus.in_base;
               exp_next   = bus.in_exp;
               acc_next   = ONE;
               idx_next   = IDX_TOP;
               state_next = S_SQ;
            end
         end

         // Every exponent bit gets one squaring; the accumulator starts at 1, so the
         // first squaring is harmless and the step count stays fixed at EXP_W.
         S_SQ: begin
            in1_next = acc_reg;
            in2_next = acc_reg;
            acc_next = bus.ip_result;
            if (exp_bit) begin
               state_next = S_MUL;
            end else if (idx_last) begin
               state_next = S_DONE;
            end else begin
               idx_next = idx_reg - IDX_ONE;
            end
         end

         // A set bit folds the base in after its squaring; the index only
         // advances once that bit is fully consumed.
         S_MUL: begin
            in1_next = acc_reg;
            in2_next = base_reg;
            acc_next = bus.ip_result;
            if (idx_last) begin
               state_next = S_DONE;
            end else begin
               idx_next   = idx_reg - IDX_ONE;
               state_next = S_SQ;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         poly_reg  <= '0;
         base_reg  <= '0;
         exp_reg   <= '0;
         acc_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         poly_reg  <= poly_next;
         base_reg  <= base_next;
         exp_reg   <= exp_next;
         acc_reg   <= acc_next;
         idx_reg   <= idx_next;
      end
   end

   assign is_done       = (state_reg == S_DONE);
   assign bus.busy      = (state_reg != S_IDLE);
   assign bus.out_valid = is_done;
   assign bus.ip_poly   = poly_reg;
   assign bus.ip_in1    = in1_next;
   assign bus.ip_in2    = in2_next;

   // The result bus is forced to zero outside the DONE pulse so that downstream
   // logic never sees intermediate accumulator values.
   generate
      for (genvar gi = 0; gi < DEG; gi++) begin : g_result
         assign bus.out_result[gi] = acc_reg[gi] & is_done;
      end
   endgenerate

endmodule

// File: tb/tb_gf2k_exp_ctrl.sv
module tb_gf2k_exp_ctrl;

   localparam int DEG   = 4;
   localparam int EXP_W = 4;
   localparam logic [DEG:0] POLY = 5'b10011;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   logic mon_en;
   logic [DEG-1:0] mon_base;

   gf2k_exp_ctrl_if #(.DEG(DEG), .EXP_W(EXP_W)) bus ();

   gf2k_exp_ctrl #(.DEG(DEG), .EXP_W(EXP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Software GF(2^DEG) multiplier: shift-and-add with reduction by poly.
   function automatic logic [DEG-1:0] gf_mul(input logic [DEG-1:0] a,
                                             input logic [DEG-1:0] b,
                                             input logic [DEG:0]   p);
      logic [DEG:0]   aa;
      logic [DEG-1:0] r;
      aa = {1'b0, a};
      r  = '0;
      for (int i = 0; i < DEG; i++) begin
         if (b[i]) r = r ^ aa[DEG-1:0];
         aa = aa << 1;
         if (aa[DEG]) aa = aa ^ p;
      end
      return r;
   endfunction

   // Exponent by repeated multiplication, independent of the square-and-multiply order.
   function automatic logic [DEG-1:0] gf_pow(input logic [DEG-1:0] a,
                                             input logic [EXP_W-1:0] e,
                                             input logic [DEG:0] p);
      logic [DEG-1:0] r;
      r = 4'h1;
      for (int i = 0; i < int'(e); i++) r = gf_mul(r, a, p);
      return r;
   endfunction

   // The multiplier IP stand-in.
   assign bus.ip_result = gf_mul(bus.ip_in1, bus.ip_in2, bus.ip_poly);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Track the base of the job actually accepted so the monitor can recognise MUL operands.
   always @(posedge clk) begin
      if (!rst && !bus.busy && bus.in_valid) mon_base <= bus.in_base;
   end

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (!bus.out_valid) chk("mon_res_zero", {28'd0, bus.out_result}, 32'd0);
         if (!bus.busy || bus.out_valid) begin
            chk("mon_in1_idle", {28'd0, bus.ip_in1}, 32'd0);
            chk("mon_in2_idle", {28'd0, bus.ip_in2}, 32'd0);
         end else begin
            chk("mon_sq_or_mul",
                {31'd0, (bus.ip_in1 == bus.ip_in2) || (bus.ip_in2 == mon_base)}, 32'd1);
         end
      end
   end

   // Issue one job from an IDLE cycle and wait for its result pulse.
   task automatic run_job(input logic [DEG-1:0] a, input logic [EXP_W-1:0] e,
                          input logic [DEG-1:0] exp_res, input int exp_lat, input string tag);
      int lat;
      bus.in_base  = a;
      bus.in_exp   = e;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.out_valid) begin
            lat = k;
            break;
         end
         chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
         @(posedge clk); #1;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, {28'd0, bus.out_result}, {28'd0, exp_res});
      @(posedge clk); #1;
      chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int pulses;
      int k;
      logic [DEG-1:0]   ra;
      logic [EXP_W-1:0] re;

      n_vec        = 0;
      n_err        = 0;
      mon_en       = 1'b0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_poly  = '0;
      bus.in_base  = '0;
      bus.in_exp   = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
      chk("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
      chk("rst_result",  {28'd0, bus.out_result}, 32'd0);
      chk("rst_ip_poly", {27'd0, bus.ip_poly}, 32'd0);
      chk("rst_ip_in1",  {28'd0, bus.ip_in1}, 32'd0);
      chk("rst_ip_in2",  {28'd0, bus.ip_in2}, 32'd0);
      rst         = 1'b0;
      mon_en      = 1'b1;
      bus.in_poly = POLY;
      @(posedge clk); #1;

      // Directed vectors, results computed by hand in GF(16) mod x^4+x+1.
      run_job(4'h2, 4'h4, 4'h3, 6, "a2_e4");
      chk("ip_poly_latched", {27'd0, bus.ip_poly}, {27'd0, POLY});
      run_job(4'h2, 4'hF, 4'h1, 9, "a2_eF");
      run_job(4'h2, 4'h7, 4'hB, 8, "a2_e7");
      run_job(4'h0, 4'h0, 4'h1, 5, "a0_e0");
      run_job(4'h0, 4'h5, 4'h0, 7, "a0_e5");
      run_job(4'h3, 4'h2, 4'h5, 6, "a3_e2");
      run_job(4'h8, 4'h3, 4'hA, 7, "a8_e3");

      // in_valid held high: new operands during the job are ignored; the second
      // job starts in the IDLE cycle after DONE.
      bus.in_base  = 4'h2;
      bus.in_exp   = 4'h4;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_base = 4'h3;
      bus.in_exp  = 4'h2;
      pulses = 0;
      k = 1;
      while (k <= 30) begin
         if (bus.out_valid) begin
            pulses++;
            if (pulses == 1) begin
               chk("hold_lat1", k, 6);
               chk("hold_res1", {28'd0, bus.out_result}, 32'h3);
            end else begin
               chk("hold_lat2", k, 13);
               chk("hold_res2", {28'd0, bus.out_result}, 32'h5);
               bus.in_valid = 1'b0;
               break;
            end
         end
         if (k == 7) chk("hold_idle_gap", {31'd0, bus.busy}, 32'd0);
         @(posedge clk); #1;
         k++;
      end
      bus.in_valid = 1'b0;
      chk("hold_pulses", pulses, 2);
      @(posedge clk); #1;
      chk("hold_end_idle", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;

      // Reset while in MUL aborts the job.
      bus.in_base  = 4'h2;
      bus.in_exp   = 4'hF;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mul_ip_in1", {28'd0, bus.ip_in1}, 32'h1);
      chk("mul_ip_in2", {28'd0, bus.ip_in2}, 32'h2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy",    {31'd0, bus.busy}, 32'd0);
      chk("abort_valid",   {31'd0, bus.out_valid}, 32'd0);
      chk("abort_result",  {28'd0, bus.out_result}, 32'd0);
      chk("abort_ip_poly", {27'd0, bus.ip_poly}, 32'd0);
      chk("abort_ip_in1",  {28'd0, bus.ip_in1}, 32'd0);
      chk("abort_ip_in2",  {28'd0, bus.ip_in2}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
         @(posedge clk); #1;
      end
      run_job(4'h2, 4'h7, 4'hB, 8, "post_rst");

      // Random jobs against the software model.
      for (int i = 0; i < 10; i++) begin
         ra = 4'($urandom_range(0, 15));
         re = 4'($urandom_range(0, 15));
         run_job(ra, re, gf_pow(ra, re, POLY), 1 + EXP_W + $countones(re), "rand");
      end

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
